// File: rtl/ahb_posted_write_buffer.sv
// AHB-Lite bridge that posts upstream writes into a small FIFO and drains them downstream;
// reads wait for the FIFO and master to go idle so program order is preserved.
module ahb_posted_write_buffer #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   ahbls_hready_resp,
    input  logic                   ahbls_hready,
    output logic                   ahbls_hresp,
    input  logic [W_ADDR-1:0]      ahbls_haddr,
    input  logic                   ahbls_hwrite,
    input  logic [1:0]             ahbls_htrans,
    input  logic [2:0]             ahbls_hsize,
    input  logic [W_DATA-1:0]      ahbls_hwdata,
    output logic [W_DATA-1:0]      ahbls_hrdata,
    output logic [W_ADDR-1:0]      ahbm_haddr,
    output logic                   ahbm_hwrite,
    output logic [1:0]             ahbm_htrans,
    output logic [2:0]             ahbm_hsize,
    output logic [W_DATA-1:0]      ahbm_hwdata,
    input  logic [W_DATA-1:0]      ahbm_hrdata,
    input  logic                   ahbm_hready,
    input  logic                   ahbm_hresp,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   bus_err
);

    localparam int unsigned W_PTR = $clog2(DEPTH);
    localparam int unsigned W_CNT = W_PTR + 1;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {M_IDLE, M_WA, M_WD, M_RA, M_RD} mstate_t;

    mstate_t state, state_next;

    logic              pend_valid, pend_write, rd_done;
    logic [W_ADDR-1:0] pend_addr;
    logic [2:0]        pend_size;

    logic [W_ADDR-1:0] mem_addr [DEPTH];
    logic [2:0]        mem_size [DEPTH];
    logic [W_DATA-1:0] mem_data [DEPTH];
    logic [W_PTR-1:0]  wr_ptr, rd_ptr;
    logic [W_CNT-1:0]  count, count_next;

    logic addr_accept, data_done, full, push, pop, rd_wait;
    logic unused_htrans0;

    assign unused_htrans0 = ahbls_htrans[0];

    // SEQ folds into NONSEQ: only htrans[1] marks a real transfer
    assign addr_accept = ahbls_htrans[1] && ahbls_hready;
    assign full        = (count == W_CNT'(DEPTH));
    assign push        = pend_valid && pend_write && !full;
    assign pop         = (state == M_WD) && ahbm_hready;
    assign rd_wait     = pend_valid && !pend_write && !rd_done;
    assign data_done   = pend_valid && ahbls_hready_resp;

    assign ahbls_hresp = 1'b0;
    assign fifo_level  = count;

    // Upstream data-phase ready, decoded from registered state only
    always_comb begin
        ahbls_hready_resp = 1'b1;
        if (pend_valid) begin
            ahbls_hready_resp = pend_write ? !full : rd_done;
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + W_CNT'(1);
            2'b01:   count_next = count - W_CNT'(1);
            default: count_next = count;
        endcase
    end

    // Master FSM next-state and downstream bus decode
    always_comb begin
        state_next  = state;
        ahbm_htrans = HTRANS_IDLE;
        ahbm_haddr  = '0;
        ahbm_hwrite = 1'b0;
        ahbm_hsize  = '0;
        ahbm_hwdata = '0;
        case (state)
            M_IDLE: begin
                if (rd_wait && (count == '0)) begin
                    state_next = M_RA;
                end else if (count != '0) begin
                    state_next = M_WA;
                end
            end
            M_WA: begin
                ahbm_htrans = HTRANS_NONSEQ;
                ahbm_hwrite = 1'b1;
                ahbm_haddr  = mem_addr[rd_ptr];
                ahbm_hsize  = mem_size[rd_ptr];
                if (ahbm_hready) state_next = M_WD;
            end
            M_WD: begin
                ahbm_hwdata = mem_data[rd_ptr];
                if (ahbm_hready) begin
                    state_next = ((count > W_CNT'(1) || push) && !rd_wait) ? M_WA : M_IDLE;
                end
            end
            M_RA: begin
                ahbm_htrans = HTRANS_NONSEQ;
                ahbm_haddr  = pend_addr;
                ahbm_hsize  = pend_size;
                if (ahbm_hready) state_next = M_RD;
            end
            M_RD: begin
                if (ahbm_hready) state_next = M_IDLE;
            end
            default: state_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= M_IDLE;
            pend_valid   <= 1'b0;
            pend_write   <= 1'b0;
            pend_addr    <= '0;
            pend_size    <= '0;
            rd_done      <= 1'b0;
            ahbls_hrdata <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus_err      <= 1'b0;
        end else begin
            state <= state_next;
            if (addr_accept) begin
                pend_valid <= 1'b1;
                pend_write <= ahbls_hwrite;
                pend_addr  <= ahbls_haddr;
                pend_size  <= ahbls_hsize;
            end else if (data_done) begin
                pend_valid <= 1'b0;
            end
            if ((state == M_RD) && ahbm_hready) begin
                ahbls_hrdata <= ahbm_hrdata;
                rd_done      <= 1'b1;
            end else if (data_done) begin
                rd_done <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + W_PTR'(1);
            if (pop)  rd_ptr <= rd_ptr + W_PTR'(1);
            count <= count_next;
            if (((state == M_WD) || (state == M_RD)) && ahbm_hresp) bus_err <= 1'b1;
        end
    end

    // FIFO storage carries no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= pend_addr;
            mem_size[wr_ptr] <= pend_size;
            mem_data[wr_ptr] <= ahbls_hwdata;
        end
    end

endmodule

// File: tb/tb_ahb_posted_write_buffer.sv
// Directed bench for ahb_posted_write_buffer with a transaction-level model checked every cycle.
module tb_ahb_posted_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ahbls_hready_resp, ahbls_hready, ahbls_hresp;
    logic [31:0] ahbls_haddr, ahbls_hwdata, ahbls_hrdata;
    logic        ahbls_hwrite;
    logic [1:0]  ahbls_htrans;
    logic [2:0]  ahbls_hsize;
    logic [31:0] ahbm_haddr, ahbm_hwdata, ahbm_hrdata;
    logic        ahbm_hwrite, ahbm_hready, ahbm_hresp;
    logic [1:0]  ahbm_htrans;
    logic [2:0]  ahbm_hsize;
    logic [2:0]  fifo_level;
    logic        bus_err;

    logic        ds_ready, ds_err;
    logic [31:0] ds_rdata;

    assign ahbls_hready = ahbls_hready_resp;
    assign ahbm_hready  = ds_ready;
    assign ahbm_hresp   = ds_err;
    assign ahbm_hrdata  = ds_rdata;

    ahb_posted_write_buffer #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ahbls_hready_resp(ahbls_hready_resp), .ahbls_hready(ahbls_hready),
        .ahbls_hresp(ahbls_hresp), .ahbls_haddr(ahbls_haddr), .ahbls_hwrite(ahbls_hwrite),
        .ahbls_htrans(ahbls_htrans), .ahbls_hsize(ahbls_hsize), .ahbls_hwdata(ahbls_hwdata),
        .ahbls_hrdata(ahbls_hrdata),
        .ahbm_haddr(ahbm_haddr), .ahbm_hwrite(ahbm_hwrite), .ahbm_htrans(ahbm_htrans),
        .ahbm_hsize(ahbm_hsize), .ahbm_hwdata(ahbm_hwdata), .ahbm_hrdata(ahbm_hrdata),
        .ahbm_hready(ahbm_hready), .ahbm_hresp(ahbm_hresp),
        .fifo_level(fifo_level), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } xfer_t;

    // Model state: written only by the monitor process
    xfer_t       exp_q[$];
    xfer_t       ds_log[$];
    logic [31:0] mem [logic [31:0]];
    int          m_level;
    logic        m_bus_err, m_rd_ready;
    logic [31:0] m_rd_val;
    logic        up_valid, up_wr;
    logic [31:0] up_addr;
    logic [2:0]  up_size;
    logic        ds_valid, ds_wr;
    logic [31:0] ds_addr;
    logic [2:0]  ds_size;

    // Monitor: compares DUT against the transaction model on every falling edge
    initial begin
        xfer_t e;
        xfer_t l;
        mem[32'h400] = 32'hCAFEF00D;
        ds_rdata   = '0;
        m_level    = 0;
        m_bus_err  = 1'b0;
        m_rd_ready = 1'b0;
        m_rd_val   = '0;
        up_valid   = 1'b0;
        ds_valid   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_level = 0; m_bus_err = 1'b0; m_rd_ready = 1'b0;
                up_valid = 1'b0; ds_valid = 1'b0; ds_rdata = '0;
                exp_q.delete();
                chk("rst_level",  32'(fifo_level),        32'd0);
                chk("rst_htrans", 32'(ahbm_htrans),       32'd0);
                chk("rst_bus_err", 32'(bus_err),          32'd0);
                chk("rst_hready", 32'(ahbls_hready_resp), 32'd1);
                chk("rst_hrdata", ahbls_hrdata,           32'd0);
            end else begin
                chk("level",   32'(fifo_level), 32'(m_level));
                chk("bus_err", 32'(bus_err),    32'(m_bus_err));
                chk("hresp_up", 32'(ahbls_hresp), 32'd0);
                chk("htrans_legal", 32'(ahbm_htrans == 2'b00 || ahbm_htrans == 2'b10), 32'd1);
                if (up_valid) begin
                    if (up_wr) chk("wr_ready", 32'(ahbls_hready_resp), 32'(m_level < DEPTH));
                    else       chk("rd_ready", 32'(ahbls_hready_resp), 32'(m_rd_ready));
                    if (ahbls_hready_resp) begin
                        if (up_wr) begin
                            exp_q.push_back('{wr: 1'b1, addr: up_addr, size: up_size, data: ahbls_hwdata});
                            m_level++;
                        end else begin
                            chk("rd_data", ahbls_hrdata, m_rd_val);
                            m_rd_ready = 1'b0;
                        end
                        up_valid = 1'b0;
                    end
                end else begin
                    chk("idle_ready", 32'(ahbls_hready_resp), 32'd1);
                end
                if (ahbls_htrans[1] && ahbls_hready) begin
                    up_valid = 1'b1; up_wr = ahbls_hwrite;
                    up_addr = ahbls_haddr; up_size = ahbls_hsize;
                    if (!ahbls_hwrite)
                        exp_q.push_back('{wr: 1'b0, addr: ahbls_haddr, size: ahbls_hsize, data: 32'd0});
                end
                if (ds_valid) begin
                    if (ahbm_hresp) m_bus_err = 1'b1;
                    if (ahbm_hready) begin
                        chk("ds_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("ds_wr",   32'(ds_wr),   32'(e.wr));
                            chk("ds_addr", ds_addr,      e.addr);
                            chk("ds_size", 32'(ds_size), 32'(e.size));
                            if (e.wr) chk("ds_wdata", ahbm_hwdata, e.data);
                        end
                        l = '{wr: ds_wr, addr: ds_addr, size: ds_size,
                              data: ds_wr ? ahbm_hwdata : ahbm_hrdata};
                        ds_log.push_back(l);
                        if (ds_wr) begin
                            m_level--;
                            if (!ahbm_hresp) mem[ds_addr] = ahbm_hwdata;
                        end else begin
                            m_rd_ready = 1'b1;
                            m_rd_val   = ahbm_hrdata;
                        end
                        ds_valid = 1'b0;
                    end
                end
                if (ahbm_htrans == 2'b10 && ahbm_hready) begin
                    ds_valid = 1'b1; ds_wr = ahbm_hwrite;
                    ds_addr = ahbm_haddr; ds_size = ahbm_hsize;
                    if (!ahbm_hwrite) ds_rdata = mem.exists(ahbm_haddr) ? mem[ahbm_haddr] : 32'd0;
                end
            end
        end
    end

    // Upstream operation list driven as pipelined AHB transfers
    logic        op_wr    [8];
    logic [31:0] op_addr  [8];
    logic [2:0]  op_size  [8];
    logic [31:0] op_wdata [8];
    int          op_wait  [8];
    logic [31:0] op_rdata [8];

    task automatic set_op(input int k, input logic wr, input logic [31:0] a,
                          input logic [2:0] s, input logic [31:0] d);
        op_wr[k] = wr; op_addr[k] = a; op_size[k] = s; op_wdata[k] = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run_ops(input int n);
        int   i = 0;
        int   dph = -1;
        int   guard = 0;
        logic rdy;
        for (int k = 0; k < n; k++) op_wait[k] = 0;
        while ((i < n || dph >= 0) && guard < 200) begin
            if (i < n) begin
                ahbls_htrans = 2'b10; ahbls_haddr = op_addr[i];
                ahbls_hwrite = op_wr[i]; ahbls_hsize = op_size[i];
            end else begin
                ahbls_htrans = 2'b00; ahbls_haddr = '0; ahbls_hwrite = 1'b0; ahbls_hsize = '0;
            end
            ahbls_hwdata = (dph >= 0) ? op_wdata[dph] : 32'd0;
            @(negedge clk);
            rdy = ahbls_hready_resp;
            if (rdy && dph >= 0) op_rdata[dph] = ahbls_hrdata;
            @(posedge clk); #1;
            guard++;
            if (rdy) begin
                dph = (i < n) ? i : -1;
                if (i < n) i++;
            end else if (dph >= 0) begin
                op_wait[dph]++;
            end
        end
        chk("run_ops_bound", 32'(guard < 200), 32'd1);
        ahbls_htrans = 2'b00; ahbls_hwdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst_n = 1'b0; ds_ready = 1'b1; ds_err = 1'b0;
        ahbls_htrans = '0; ahbls_haddr = '0; ahbls_hwrite = 1'b0;
        ahbls_hsize = '0; ahbls_hwdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Single posted write, zero-wait downstream
        b = ds_log.size();
        set_op(0, 1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
        run_ops(1);
        idle(8);
        chk("t1_wait",  32'(op_wait[0]), 32'd0);
        chk("t1_count", 32'(ds_log.size() - b), 32'd1);
        chk("t1_addr",  ds_log[b].addr, 32'h100);
        chk("t1_data",  ds_log[b].data, 32'hDEADBEEF);
        chk("t1_level", 32'(fifo_level), 32'd0);

        // Five writes into a stalled downstream: fifth stalls on a full FIFO
        b = ds_log.size();
        ds_ready = 1'b0;
        for (int k = 0; k < 5; k++) set_op(k, 1'b1, 32'(16 * (k + 1)), 3'd2, 32'(k + 1));
        fork
            run_ops(5);
            begin idle(10); ds_ready = 1'b1; end
        join
        idle(14);
        for (int k = 0; k < 4; k++) chk("t2_nowait", 32'(op_wait[k]), 32'd0);
        chk("t2_stall", 32'(op_wait[4]), 32'd7);
        chk("t2_count", 32'(ds_log.size() - b), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk("t2_order_addr", ds_log[b + k].addr, 32'(16 * (k + 1)));
            chk("t2_order_data", ds_log[b + k].data, 32'(k + 1));
        end

        // Write then read of the same address: read waits for the drain
        b = ds_log.size();
        set_op(0, 1'b1, 32'h200, 3'd2, 32'h11223344);
        set_op(1, 1'b0, 32'h200, 3'd2, 32'h0);
        run_ops(2);
        idle(4);
        chk("t3_rdata",  op_rdata[1], 32'h11223344);
        chk("t3_rwait",  32'(op_wait[1]), 32'd6);
        chk("t3_first_is_wr", 32'(ds_log[b].wr), 32'd1);
        chk("t3_second_is_rd", 32'(ds_log[b + 1].wr), 32'd0);

        // Read with empty FIFO: minimum latency
        b = ds_log.size();
        set_op(0, 1'b0, 32'h400, 3'd2, 32'h0);
        run_ops(1);
        idle(2);
        chk("t4_wait",  32'(op_wait[0]), 32'd3);
        chk("t4_rdata", op_rdata[0], 32'hCAFEF00D);
        chk("t4_addr",  ds_log[b].addr, 32'h400);

        // Byte write passes address and size through unchanged
        b = ds_log.size();
        set_op(0, 1'b1, 32'h303, 3'd0, 32'h000000AB);
        run_ops(1);
        idle(6);
        chk("t5_addr", ds_log[b].addr, 32'h303);
        chk("t5_size", 32'(ds_log[b].size), 32'd0);

        // Downstream error then reset mid-drain with two entries queued
        ds_err = 1'b1; ds_ready = 1'b0;
        for (int k = 0; k < 3; k++) set_op(k, 1'b1, 32'h500 + 32'(4 * k), 3'd2, 32'hA0 + 32'(k));
        run_ops(3);
        chk("t6_level_full", 32'(fifo_level), 32'd3);
        ds_ready = 1'b1;
        idle(2);
        ds_ready = 1'b0;
        chk("t6_bus_err", 32'(bus_err), 32'd1);
        chk("t6_level",   32'(fifo_level), 32'd2);
        rst_n = 1'b0;
        idle(2);
        chk("t6_rst_bus_err", 32'(bus_err), 32'd0);
        chk("t6_rst_level",   32'(fifo_level), 32'd0);
        chk("t6_rst_htrans",  32'(ahbm_htrans), 32'd0);
        rst_n = 1'b1; ds_err = 1'b0; ds_ready = 1'b1;
        b = ds_log.size();
        idle(12);
        chk("t6_no_traffic", 32'(ds_log.size()), 32'(b));
        chk("t6_bus_err_after", 32'(bus_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
